// File: rtl/sram_param_clr.sv
// Parametrised single-port SRAM with registered reads and a zeroing sweep.
// Define SRAM_PARITY_EN to store an even-parity bit per word and flag perr.
module sram_param_clr #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  inbits,
  output logic [WIDTH-1:0]  outbits,
  output logic              rvalid,
  output logic              busy,
  output logic              perr
);

`ifdef SRAM_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  typedef enum logic {
    CLEAR,
    IDLE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              rv_q, rv_d;
  logic              perr_q, perr_d;

  logic [MW-1:0]     mem_q [DEPTH];
  logic              idle;
  logic              in_rng;
  logic              acc_we;
  logic              acc_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [MW-1:0]     mem_wd;

  assign idle   = (state_q == IDLE);
  assign in_rng = (32'(addr) < DEPTH);
  // clr takes the whole cycle: any access alongside it is dropped
  assign acc_we = idle & ~clr & we & in_rng;
  assign acc_re = idle & ~clr & re;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    rv_d   = acc_re;
    out_d  = out_q;
    perr_d = 1'b0;
    if (acc_re) begin
      if (in_rng) begin
        out_d = mem_q[addr][WIDTH-1:0];
`ifdef SRAM_PARITY_EN
        perr_d = ^mem_q[addr];
`endif
      end else begin
        out_d = '0;
      end
    end
  end

  always_comb begin
    mem_we = rst & (~idle | acc_we);
    mem_a  = idle ? addr : cnt_q;
    mem_wd = '0;
    if (idle) begin
`ifdef SRAM_PARITY_EN
      mem_wd = {^inbits, inbits};
`else
      mem_wd = inbits;
`endif
    end
  end

  // storage has no reset; only the sweep defines its contents
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_a] <= mem_wd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      out_q   <= '0;
      rv_q    <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rv_q    <= rv_d;
      perr_q  <= perr_d;
    end
  end

  assign outbits = out_q;
  assign rvalid  = rv_q;
  assign busy    = ~idle;
  assign perr    = perr_q;

endmodule

// File: tb/tb_sram_param_clr.sv
// Scoreboard bench for sram_param_clr: 16x128 instance plus an 8x100 one.
// Monitors pop expected read data whenever rvalid is seen.
module tb_sram_param_clr;

  typedef struct {
    logic [15:0] d;
    logic        p;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, we, re, clr;
  logic [6:0]  addr;
  logic [15:0] din, dout;
  logic        rv, busy, perr;

  logic        rst_b, we_b, re_b, clr_b;
  logic [6:0]  addr_b;
  logic [7:0]  din_b, dout_b;
  logic        rv_b, busy_b, perr_b;

  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        ea, eb;
  logic [15:0] model [128];
  int          total = 0;
  int          bad = 0;
  int          n;

  always #5 clk = ~clk;

  sram_param_clr #(.WIDTH(16), .DEPTH(128), .ADDR_W(7)) u_dut (
    .clk(clk), .rst(rst), .we(we), .re(re), .clr(clr),
    .addr(addr), .inbits(din), .outbits(dout),
    .rvalid(rv), .busy(busy), .perr(perr)
  );

  sram_param_clr #(.WIDTH(8), .DEPTH(100), .ADDR_W(7)) u_d100 (
    .clk(clk), .rst(rst_b), .we(we_b), .re(re_b), .clr(clr_b),
    .addr(addr_b), .inbits(din_b), .outbits(dout_b),
    .rvalid(rv_b), .busy(busy_b), .perr(perr_b)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rv) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_rvalid", rv, 0);
      end else begin
        ea = qa.pop_front();
        chk("a_data", dout, ea.d);
        chk("a_perr", perr, ea.p);
      end
    end else begin
      chk("a_perr_norv", perr, 0);
    end
  end

  always @(negedge clk) begin
    if (rv_b) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_rvalid", rv_b, 0);
      end else begin
        eb = qb.pop_front();
        chk("b_data", dout_b, eb.d);
        chk("b_perr", perr_b, eb.p);
      end
    end
  end

  task automatic rd(input int a, input logic [15:0] d, input logic p);
    re   = 1'b1;
    addr = 7'(a);
    qa.push_back('{d: d, p: p});
    tick();
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    we   = 1'b1;
    addr = 7'(a);
    din  = d;
    tick();
    we   = 1'b0;
  endtask

  task automatic count_busy(input string nm, input int exp);
    n = 0;
    while (busy && n < 1000) begin
      n++;
      if (n == 10) chk({nm, "_rv_while_busy"}, rv, 0);
      tick();
    end
    re = 1'b0;
    chk(nm, n, exp);
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 128; i++) rd(i, 16'h0, 1'b0);
    re = 1'b0;
    tick();
    chk("a_rv_drop", rv, 0);
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; re = 1'b0; clr = 1'b0;
    addr = '0; din = '0;
    rst_b = 1'b0; we_b = 1'b0; re_b = 1'b0; clr_b = 1'b0;
    addr_b = '0; din_b = '0;
    repeat (3) tick();
    chk("rst_outbits", dout, 0);
    chk("rst_rvalid", rv, 0);
    chk("rst_busy", busy, 1);
    chk("rst_perr", perr, 0);

    rst = 1'b1;
    count_busy("a_reset_busy", 128);
    read_all_zero();

    for (int i = 0; i < 128; i++) begin
      model[i] = 16'($urandom);
      wr(i, model[i]);
    end
    for (int i = 0; i < 128; i++) rd(i, model[i], 1'b0);
    re = 1'b0;
    tick();
    chk("a_rv_drop_after_rb", rv, 0);

    wr(5, 16'h1234);
    we = 1'b1; re = 1'b1; addr = 7'd5; din = 16'hBEEF;
    qa.push_back('{d: 16'h1234, p: 1'b0});
    tick();
    we = 1'b0;
    rd(5, 16'hBEEF, 1'b0);
    re = 1'b0;
    tick();

    we = 1'b1; clr = 1'b1; addr = 7'd7; din = 16'hFFFF;
    tick();
    we = 1'b0; clr = 1'b0;
    re = 1'b1; addr = 7'd3;
    count_busy("a_clr_busy", 128);
    read_all_zero();

    for (int i = 0; i < 128; i++) wr(i, 16'(i + 1));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (60) tick();
    chk("a_busy_at_60", busy, 1);
    rst = 1'b0;
    #2;
    chk("a_midrst_busy", busy, 1);
    chk("a_midrst_rv", rv, 0);
    tick();
    rst = 1'b1;
    count_busy("a_restart_busy", 128);
    read_all_zero();

`ifdef SRAM_PARITY_EN
    wr(3, 16'h00FF);
    rd(3, 16'h00FF, 1'b0);
    re = 1'b0;
    force u_dut.mem_q[3][0] = 1'b0;
    tick();
    rd(3, 16'h00FE, 1'b1);
    rd(4, 16'h0000, 1'b0);
    re = 1'b0;
    tick();
    chk("a_perr_drop", perr, 0);
    release u_dut.mem_q[3][0];
`endif

    rst_b = 1'b1;
    n = 0;
    while (busy_b && n < 1000) begin
      n++;
      tick();
    end
    chk("b_busy_len", n, 100);
    we_b = 1'b1;
    addr_b = 7'd110; din_b = 8'hAA; tick();
    addr_b = 7'd99;  din_b = 8'h5C; tick();
    addr_b = 7'd0;   din_b = 8'h11; tick();
    we_b = 1'b0;
    re_b = 1'b1;
    addr_b = 7'd110; qb.push_back('{d: 16'h00, p: 1'b0}); tick();
    addr_b = 7'd99;  qb.push_back('{d: 16'h5C, p: 1'b0}); tick();
    addr_b = 7'd0;   qb.push_back('{d: 16'h11, p: 1'b0}); tick();
    addr_b = 7'd100; qb.push_back('{d: 16'h00, p: 1'b0}); tick();
    re_b = 1'b0;
    tick();
    chk("b_rv_drop", rv_b, 0);

    repeat (3) tick();
    chk("a_drain", qa.size(), 0);
    chk("b_drain", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_param_clr.md
# sram_param_clr

Parametrised single-port synchronous SRAM, the next generation of the team's fixed 16x128 memory. It adds configurable width and depth, registered reads with a valid strobe, and a hardware clear engine that zeroes every word after reset or on request. It sits behind datapath blocks that need scratch storage with a known-zero start state.

## Interface
- WIDTH, 16, data word width in bits (>=1)
- DEPTH, 128, number of words (>=2, need not be a power of two)
- ADDR_W, 7, address width; must satisfy 2^ADDR_W >= DEPTH
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- we  in  1  write enable, sampled on rising clk
- re  in  1  read enable, sampled on rising clk
- clr  in  1  clear request, single-cycle pulse, honoured only in IDLE
- addr  in  ADDR_W  word address for read and write
- inbits  in  WIDTH  write data
- outbits  out  WIDTH  registered read data
- rvalid  out  1  high for one cycle when outbits carries new read data
- busy  out  1  clear engine running; we/re ignored
- perr  out  1  parity error on the current read (see Configuration)

## Operation
- Two-state FSM: CLEAR, IDLE. Clear counter is ADDR_W bits wide.
- Reset (rst=0): state=CLEAR, counter=0, outbits=0, rvalid=0, busy=1, perr=0. Memory contents are not touched asynchronously.
- CLEAR: each rising edge writes 0 to mem[counter] and increments counter. The edge that writes DEPTH-1 moves to IDLE and drops busy.
- IDLE, we=1, addr<DEPTH: mem[addr] <= inbits.
- IDLE, re=1, addr<DEPTH: outbits <= mem[addr], rvalid <= 1.
- IDLE, re=1, addr>=DEPTH: outbits <= 0, rvalid <= 1, no error. A write with addr>=DEPTH is dropped.
- re=0 or busy: rvalid <= 0, and outbits holds its last value.
- we and re in the same cycle to the same addr: read-first. outbits gets the old contents and the write still lands.
- clr=1 in IDLE: next state is CLEAR, counter <= 0, and busy is high from the next cycle. A we or re in that same cycle is dropped (clr wins). clr during CLEAR is ignored; the sweep does not restart.
- rst asserted mid-clear restarts the sweep from address 0 after release.

## Timing
- Read latency is 1 cycle: with re sampled high at edge N, outbits and rvalid are valid after edge N and rvalid falls after edge N+1 unless re is still high.
- Write data is visible to a read issued on the cycle after the write.
- busy is high for exactly DEPTH cycles after rst deasserts. The first access is accepted on the edge following the DEPTH-th edge.
- A clr pulse sampled at edge N gives busy=1 from after edge N until after edge N+DEPTH.
- No combinational path from inputs to outputs.

## Configuration
- SRAM_PARITY_EN defined: storage is WIDTH+1 bits per word. Writes store even parity (XOR of inbits) in the extra bit, and clear writes parity 0. On every accepted read, perr <= XOR of the stored word and its parity bit, registered alongside outbits. perr is 0 whenever rvalid is 0 and for out-of-range reads.
- SRAM_PARITY_EN undefined: storage is WIDTH bits and perr is a constant 0.

## Test plan
- Reset then sweep: with WIDTH=16 and DEPTH=128, deassert rst and count 128 cycles of busy=1. Then read all 128 addresses: every read returns 0x0000 with rvalid=1 one cycle after re.
- Write/read: write $random to addresses 0..127, then read them back in order. Each outbits matches its write one cycle later, and rvalid drops the cycle after re falls.
- Read-first collision: load 0x1234 at address 5, then apply we=1, re=1, addr=5, inbits=0xBEEF. outbits must be 0x1234; a read on the next cycle returns 0xBEEF.
- Clear mid-use: fill memory, pulse clr with we=1 in the same cycle. The write is dropped, busy is high for 128 cycles, re is ignored while busy (rvalid=0), and all words read 0 afterwards. Also assert rst at counter 60 and check the sweep restarts with a full 128 busy cycles.
- Non-power-of-two depth (DEPTH=100, ADDR_W=7): busy lasts 100 cycles. A write to address 110 is dropped, and a read of address 110 returns 0 with rvalid=1.
- With SRAM_PARITY_EN: write 0x00FF to address 3, then flip one stored data bit by hierarchical force. Reading address 3 gives perr=1 for one cycle; reading an untouched address gives perr=0. Without the macro, perr stays 0 throughout.
